// File: rtl/gray_median3x3.sv
// gray_median3x3: streaming 3x3 median filter over a raster gray stream, latency 4, zero on borders.
// Define MEDIAN_BYPASS_EN to add med_bypass, which passes the window centre through unsorted.
module gray_median3x3 #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_sync,
  input  logic              gray_valid,
  input  logic [DATA_W-1:0] gray_data,
`ifdef MEDIAN_BYPASS_EN
  input  logic              med_bypass,
`endif
  output logic              med_valid,
  output logic [DATA_W-1:0] med_data
);
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef logic [DATA_W-1:0] pix_t;
  function automatic pix_t min2(input pix_t a, input pix_t b);
    return a < b ? a : b;
  endfunction
  function automatic pix_t max2(input pix_t a, input pix_t b);
    return a < b ? b : a;
  endfunction
  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          x_last, border_in, byp_in;
  pix_t          lb1 [IMG_W];
  pix_t          lb2 [IMG_W];
  pix_t          lb1_rd, lb2_rd;
  pix_t          win_q [3][3];
  logic          v0_q, b0_q, p0_q;
  pix_t          s1_lo_q [3];
  pix_t          s1_md_q [3];
  pix_t          s1_hi_q [3];
  pix_t          c1_q;
  logic          v1_q, b1_q, p1_q;
  pix_t          s2_lo_q, s2_md_q, s2_hi_q, c2_q;
  logic          v2_q, b2_q, p2_q;
  logic          med_valid_q;
  pix_t          med_data_q;
`ifdef MEDIAN_BYPASS_EN
  assign byp_in = med_bypass;
`else
  assign byp_in = 1'b0;
`endif
  // frame_sync takes effect in its own cycle so a coincident pixel lands at (0,0)
  always_comb begin
    cur_x     = frame_sync ? '0 : x_q;
    cur_y     = frame_sync ? '0 : y_q;
    x_last    = cur_x == XW'(IMG_W - 1);
    x_d       = gray_valid ? (x_last ? '0 : cur_x + 1'b1) : cur_x;
    y_d       = (gray_valid && x_last && cur_y != YW'(IMG_H - 1)) ? cur_y + 1'b1 : cur_y;
    border_in = cur_x < XW'(2) || cur_y < YW'(2);
  end
  assign lb1_rd = lb1[cur_x];
  assign lb2_rd = lb2[cur_x];
  always_ff @(posedge clk) begin
    if (gray_valid) begin
      lb1[cur_x] <= gray_data;
      lb2[cur_x] <= lb1_rd;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      v0_q <= 1'b0;
      b0_q <= 1'b0;
      p0_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      v0_q <= gray_valid;
      b0_q <= border_in;
      p0_q <= byp_in;
      if (gray_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= gray_data;
      end
    end
  end
  // Row sort, then max-of-mins / med-of-mids / min-of-maxes, then final median
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        s1_lo_q[r] <= '0;
        s1_md_q[r] <= '0;
        s1_hi_q[r] <= '0;
      end
      c1_q <= '0;
      v1_q <= 1'b0;
      b1_q <= 1'b0;
      p1_q <= 1'b0;
      s2_lo_q <= '0;
      s2_md_q <= '0;
      s2_hi_q <= '0;
      c2_q <= '0;
      v2_q <= 1'b0;
      b2_q <= 1'b0;
      p2_q <= 1'b0;
      med_valid_q <= 1'b0;
      med_data_q <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        s1_lo_q[r] <= min2(min2(win_q[r][0], win_q[r][1]), win_q[r][2]);
        s1_md_q[r] <= med3(win_q[r][0], win_q[r][1], win_q[r][2]);
        s1_hi_q[r] <= max2(max2(win_q[r][0], win_q[r][1]), win_q[r][2]);
      end
      c1_q <= win_q[1][1];
      v1_q <= v0_q;
      b1_q <= b0_q;
      p1_q <= p0_q;
      s2_lo_q <= max2(max2(s1_lo_q[0], s1_lo_q[1]), s1_lo_q[2]);
      s2_md_q <= med3(s1_md_q[0], s1_md_q[1], s1_md_q[2]);
      s2_hi_q <= min2(min2(s1_hi_q[0], s1_hi_q[1]), s1_hi_q[2]);
      c2_q <= c1_q;
      v2_q <= v1_q;
      b2_q <= b1_q;
      p2_q <= p1_q;
      med_valid_q <= v2_q;
      med_data_q <= b2_q ? '0 : (p2_q ? c2_q : med3(s2_lo_q, s2_md_q, s2_hi_q));
    end
  end
  assign med_valid = med_valid_q;
  assign med_data  = med_data_q;
endmodule

// File: tb/tb_gray_median3x3.sv
// tb_gray_median3x3: randomized scoreboard bench for gray_median3x3 on an 8x4 image.
module tb_gray_median3x3;
  localparam int W = 8;
  localparam int H = 4;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       frame_sync = 0;
  logic       gray_valid = 0;
  logic [7:0] gray_data = 0;
  logic       med_valid;
  logic [7:0] med_data;
`ifdef MEDIAN_BYPASS_EN
  logic       med_bypass = 0;
`endif
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int img [H][W];
  int mx = 0;
  int my = 0;
  int exp_q [$];
  int stamp_q [$];
  int e, s;

  gray_median3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_sync(frame_sync),
    .gray_valid(gray_valid),
    .gray_data(gray_data),
`ifdef MEDIAN_BYPASS_EN
    .med_bypass(med_bypass),
`endif
    .med_valid(med_valid),
    .med_data(med_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(input int x, input int y, input bit byp);
    int v [9];
    int t;
    if (x < 2 || y < 2) return 0;
    if (byp) return img[y-1][x-1];
    for (int i = 0; i < 9; i++) v[i] = img[y-2+i/3][x-2+i%3];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  function automatic int pval(input int mode, input int x, input int y);
    int r;
    if (mode == 0) return 100;
    if (mode == 1) return (x == 3 && y == 1) ? 255 : 50;
    if (mode == 2) return x * 10;
    r = int'($urandom % 10);
    return r == 0 ? 0 : (r == 1 ? 255 : int'($urandom % 256));
  endfunction

  task automatic drive(input bit fs, input bit v, input int d, input bit byp);
    frame_sync = fs;
    gray_valid = v;
    gray_data  = d[7:0];
`ifdef MEDIAN_BYPASS_EN
    med_bypass = byp;
`endif
    if (fs) begin mx = 0; my = 0; end
    if (v) begin
      img[my][mx] = d;
      exp_q.push_back(model(mx, my, byp));
      stamp_q.push_back(cyc);
      if (mx == W - 1) begin
        mx = 0;
        if (my < H - 1) my++;
      end else mx++;
    end
    @(posedge clk);
    #1;
    frame_sync = 0;
    gray_valid = 0;
  endtask

  task automatic send(input int mode, input int gap, input int n);
    bit byp;
    int g;
    for (int i = 0; i < n; i++) begin
      byp = 0;
`ifdef MEDIAN_BYPASS_EN
      if (mode == 3) byp = ($urandom % 4) == 0;
`endif
      drive(i == 0, 1'b1, pval(mode, i % W, i / W), byp);
      g = gap == 1 ? 2 : (gap == 2 ? int'($urandom % 3) : 0);
      for (int k = 0; k < g; k++) drive(1'b0, 1'b0, 0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && med_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %0d with empty scoreboard", med_data);
      end else begin
        e = exp_q.pop_front();
        s = stamp_q.pop_front();
        if (med_data !== e[7:0] || cyc - s != 4) begin
          errors++;
          $display("FAIL med_out got %0d latency %0d expected %0d latency 4", med_data, cyc - s, e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    checks++;
    if (med_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", med_valid); end
    checks++;
    if (med_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", med_data); end
    send(0, 0, W * H);
    send(1, 0, W * H);
    send(2, 0, W * H);
    send(0, 1, W * H);
    send(3, 2, W * H);
    send(3, 0, 13);
    send(3, 0, W * H);
    send(3, 2, W * H);
    send(0, 0, 24);
    rst_n = 0;
    #1;
    checks++;
    if (med_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b expected 0", med_valid); end
    checks++;
    if (med_data !== 8'd0) begin errors++; $display("FAIL midreset_data got %0d expected 0", med_data); end
    exp_q.delete();
    stamp_q.delete();
    mx = 0;
    my = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    drive(1'b1, 1'b0, 0, 1'b0);
    send(3, 0, W * H);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
